mdu_sched: RTL and testbench
============================

# mdu_sched

Multiply/divide scheduler for the five-stage pipeline. It sits beside the ALU in the E stage and accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO operations. It models the fixed multi-cycle latency of the HI/LO unit and owns the HI and LO registers. It raises a stall request that freezes the F/D stages, and bubbles the D/E register, while an HI/LO-dependent instruction waits in D.

## Interface
Parameters:
- MULT_CYCLES, default 5: busy cycles for MULT/MULTU (legal range 1..15).
- DIV_CYCLES, default 10: busy cycles for DIV/DIVU (legal range 1..15).

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- start  in  1  E-stage instruction is an MDU op this cycle.
- op  in  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO; 7 is treated as NONE.
- rs_val  in  32  forwarded rs operand from the E stage.
- rt_val  in  32  forwarded rt operand from the E stage.
- md_in_D  in  1  D-stage instruction is any of mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
- busy  out  1  long operation in progress.
- stall_req  out  1  combinational: md_in_D & (busy | (start & op in 1..4)).
- hi  out  32  architectural HI (mfhi source).
- lo  out  32  architectural LO (mflo source).

## Operation
- State machine has two states, IDLE and RUN. A 4-bit down-counter `cnt` and 32-bit pending registers `p_hi` and `p_lo` support it.
- IDLE with start and op in 1..4:
  - compute the result from rs_val and rt_val;
  - latch it into p_hi/p_lo;
  - load cnt with MULT_CYCLES or DIV_CYCLES;
  - go to RUN.
- IDLE with start and op 5 or 6: hi (op 5) or lo (op 6) takes rs_val at this edge. State stays IDLE and busy stays 0.
- RUN:
  - cnt decrements each cycle;
  - when cnt==1, at that edge hi<=p_hi, lo<=p_lo, and the state returns to IDLE.
- start while in RUN is ignored: no effect on cnt, pending or hi/lo. Upstream stalling guarantees this never occurs legitimately.
- Arithmetic rules:
  - MULT: {p_hi,p_lo} = signed 64-bit product.
  - MULTU: {p_hi,p_lo} = unsigned 64-bit product.
  - DIV: p_lo = quotient truncated toward zero; p_hi = remainder, which takes the sign of the dividend (rs_val).
  - DIVU: unsigned quotient and remainder.
  - Divisor 0 (DIV or DIVU): still busy for DIV_CYCLES, but hi/lo are left unchanged at completion.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- busy = (state==RUN).
- hi/lo always show committed values only. Pending results never leak to the outputs early.

## Timing
- Reset values: busy=0, stall_req reflects its inputs only, hi=0, lo=0, state=IDLE, cnt=0, p_hi=p_lo=0.
- A reset assertion mid-RUN abandons the operation immediately. No commit occurs.
- Start accepted at edge E0:
  - busy is high in cycles E0+1 .. E0+N (N = MULT_CYCLES or DIV_CYCLES);
  - hi/lo update at the edge closing cycle E0+N, with new values visible in cycle E0+N+1;
  - busy is low in cycle E0+N+1.
- mthi/mtlo are single-cycle: the written value is visible on hi/lo the cycle after start.
- stall_req is asserted in the start cycle itself when md_in_D=1 (the start term). It then covers all N busy cycles.
- mfhi in D is released on the cycle busy falls and reads the committed value. No forwarding from p_hi/p_lo is performed.
- Back-to-back case: a new start may be accepted in the first cycle busy is 0, which is the same cycle the previous result becomes visible.

## Test plan
- Reset then idle:
  - deassert reset, hold start=0 for 3 cycles -> hi=lo=0, busy=0, stall_req=0;
  - md_in_D=1 -> stall_req=0.
- Signed MULT: rs=0xFFFFFFFE (-2), rt=3, start one cycle -> busy high exactly 5 cycles. The cycle after, hi=0xFFFFFFFF and lo=0xFFFFFFFA; both hold their prior value during busy.
- DIV with negative dividend:
  - rs=-7 (0xFFFFFFF9), rt=2 -> after 10 busy cycles lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1);
  - repeat with DIVU 7/2 -> lo=3, hi=1;
  - DIV by 0 -> busy for 10 cycles, then hi/lo unchanged.
- Stall coverage: issue MULT with md_in_D=1 (mflo waiting) -> stall_req high in the start cycle plus 5 busy cycles (6 total), then low. lo is valid in the first unstalled cycle.
- MTHI/MTLO and ignore-while-busy:
  - MTHI rs=0x12345678 -> hi=0x12345678 next cycle, busy stays 0;
  - start DIVU, then pulse start with MTLO at busy cycle 3 -> lo receives the division result only, and busy length is unchanged.
- Reset mid-operation: start MULT 0x10000 * 0x10000, then assert reset in busy cycle 2 -> busy=0 and hi=lo=0 immediately. After release, no late commit occurs (hi stays 0 for 10 cycles).

Source files
------------

// File: rtl/mdu_sched_if.sv
// E-stage <-> multiply/divide scheduler bundle: issue request, D-stage hazard
// hint, and the busy/stall/HI/LO results.
interface mdu_sched_if;
   logic        start;
   logic [2:0]  op;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic        md_in_D;
   logic        busy;
   logic        stall_req;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (
      output start, op, rs_val, rt_val, md_in_D,
      input  busy, stall_req, hi, lo
   );

   modport slave (
      input  start, op, rs_val, rt_val, md_in_D,
      output busy, stall_req, hi, lo
   );
endinterface

// File: rtl/mdu_sched.sv
// Multiply/divide scheduler: computes the result at issue, then holds it in
// pending registers for a fixed busy window before committing to HI/LO.
module mdu_sched #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input logic        clk,
   input logic        reset,
   mdu_sched_if.slave mdu
);
   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   typedef enum logic {IDLE, RUN} state_t;

   state_t      state, stateNext;
   logic [3:0]  cnt;
   logic [31:0] pHi, pLo, hiReg, loReg;
   logic        pCommit;

   logic        isLong, isMult, isSignedDiv, divZero;
   logic [63:0] prodS, prodU;
   logic [31:0] divA, divB, quoU, remU, resHi, resLo;

   assign isLong      = mdu.start && (mdu.op >= OP_MULT) && (mdu.op <= OP_DIVU);
   assign isMult      = (mdu.op == OP_MULT) || (mdu.op == OP_MULTU);
   assign isSignedDiv = (mdu.op == OP_DIV);
   assign divZero     = (mdu.rt_val == 32'd0);

   // Signed divide runs on magnitudes; signs are restored afterwards, which
   // also makes 0x80000000 / -1 wrap to 0x80000000 rem 0 without a special case.
   always_comb begin
      prodS = $signed({{32{mdu.rs_val[31]}}, mdu.rs_val}) *
              $signed({{32{mdu.rt_val[31]}}, mdu.rt_val});
      prodU = {32'd0, mdu.rs_val} * {32'd0, mdu.rt_val};
      divA  = (isSignedDiv && mdu.rs_val[31]) ? -mdu.rs_val : mdu.rs_val;
      divB  = (isSignedDiv && mdu.rt_val[31]) ? -mdu.rt_val : mdu.rt_val;
      quoU  = divZero ? 32'd0 : divA / divB;
      remU  = divZero ? 32'd0 : divA % divB;
      resHi = remU;
      resLo = quoU;
      case (mdu.op)
         OP_MULT:  {resHi, resLo} = prodS;
         OP_MULTU: {resHi, resLo} = prodU;
         OP_DIV: begin
            resLo = (mdu.rs_val[31] ^ mdu.rt_val[31]) ? -quoU : quoU;
            resHi = mdu.rs_val[31] ? -remU : remU;
         end
         default: ;
      endcase
   end

   always_comb begin
      stateNext = state;
      case (state)
         IDLE:    if (isLong) stateNext = RUN;
         RUN:     if (cnt == 4'd1) stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= stateNext;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt     <= 4'd0;
         pHi     <= 32'd0;
         pLo     <= 32'd0;
         pCommit <= 1'b0;
         hiReg   <= 32'd0;
         loReg   <= 32'd0;
      end else if (state == IDLE) begin
         if (isLong) begin
            pHi     <= resHi;
            pLo     <= resLo;
            pCommit <= !(!isMult && divZero);
            cnt     <= isMult ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
         end else if (mdu.start && mdu.op == OP_MTHI) begin
            hiReg <= mdu.rs_val;
         end else if (mdu.start && mdu.op == OP_MTLO) begin
            loReg <= mdu.rs_val;
         end
      end else begin
         // Starts seen while running are dropped on purpose.
         cnt <= cnt - 4'd1;
         if (cnt == 4'd1 && pCommit) begin
            hiReg <= pHi;
            loReg <= pLo;
         end
      end
   end

   assign mdu.busy      = (state == RUN);
   assign mdu.stall_req = mdu.md_in_D & ((state == RUN) | isLong);
   assign mdu.hi        = hiReg;
   assign mdu.lo        = loReg;
endmodule

// File: tb/tb_mdu_sched.sv
// Bench for mdu_sched: directed plan plus random op sequence against a
// 64-bit arithmetic reference of the HI/LO architectural effects.
module tb_mdu_sched;
   localparam int MULT_N = 5;
   localparam int DIV_N  = 10;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   errors = 0;
   logic [31:0] expHi = 32'd0;
   logic [31:0] expLo = 32'd0;

   mdu_sched_if m ();

   mdu_sched #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
      .clk  (clk),
      .reset(reset),
      .mdu  (m)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Architectural result of a long op, straight from the ISA arithmetic.
   task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] nHi, output logic [31:0] nLo, output logic cmt);
      longint sa, sb, q, r;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      cmt = 1'b1;
      nHi = 32'd0;
      nLo = 32'd0;
      case (o)
         3'd1: begin p = sa * sb; nHi = p[63:32]; nLo = p[31:0]; end
         3'd2: begin p = {32'd0, a} * {32'd0, b}; nHi = p[63:32]; nLo = p[31:0]; end
         3'd3: if (b == 0) cmt = 1'b0;
               else begin q = sa / sb; r = sa % sb; nLo = q[31:0]; nHi = r[31:0]; end
         default: if (b == 0) cmt = 1'b0;
                  else begin nLo = a / b; nHi = a % b; end
      endcase
   endtask

   task automatic runOp(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic mdD, input int pulseAt);
      logic [31:0] nHi, nLo;
      logic cmt;
      int n;
      model(o, a, b, nHi, nLo, cmt);
      n = (o == 3'd1 || o == 3'd2) ? MULT_N : DIV_N;
      m.start = 1'b1; m.op = o; m.rs_val = a; m.rt_val = b; m.md_in_D = mdD;
      #1;
      chk("stallStart", {31'd0, m.stall_req}, {31'd0, mdD});
      step();
      m.start = 1'b0; m.op = 3'd0; m.rs_val = $urandom; m.rt_val = $urandom;
      for (int k = 1; k <= n; k++) begin
         chk("busyRun", {31'd0, m.busy}, 32'd1);
         chk("hiHold", m.hi, expHi);
         chk("loHold", m.lo, expLo);
         chk("stallBusy", {31'd0, m.stall_req}, {31'd0, mdD});
         if (k == pulseAt) begin m.start = 1'b1; m.op = 3'd6; m.rs_val = 32'hDEADBEEF; end
         step();
         m.start = 1'b0; m.op = 3'd0;
      end
      if (cmt) begin expHi = nHi; expLo = nLo; end
      chk("busyDone", {31'd0, m.busy}, 32'd0);
      chk("hiDone", m.hi, expHi);
      chk("loDone", m.lo, expLo);
      chk("stallRelease", {31'd0, m.stall_req}, 32'd0);
      m.md_in_D = 1'b0;
   endtask

   task automatic runShort(input logic [2:0] o, input logic [31:0] a);
      m.start = 1'b1; m.op = o; m.rs_val = a; m.rt_val = $urandom; m.md_in_D = 1'b1;
      #1;
      chk("stallShort", {31'd0, m.stall_req}, 32'd0);
      step();
      m.start = 1'b0; m.md_in_D = 1'b0;
      if (o == 3'd5) expHi = a;
      if (o == 3'd6) expLo = a;
      chk("hiShort", m.hi, expHi);
      chk("loShort", m.lo, expLo);
      chk("busyShort", {31'd0, m.busy}, 32'd0);
   endtask

   initial begin
      logic [2:0]  ro;
      logic [31:0] ra, rb;
      m.start = 1'b0; m.op = 3'd0; m.rs_val = 32'd0; m.rt_val = 32'd0; m.md_in_D = 1'b0;
      repeat (2) step();
      reset = 1'b1;
      repeat (3) step();
      chk("rstHi", m.hi, 32'd0);
      chk("rstLo", m.lo, 32'd0);
      chk("rstBusy", {31'd0, m.busy}, 32'd0);
      chk("rstStall", {31'd0, m.stall_req}, 32'd0);
      m.md_in_D = 1'b1;
      #1;
      chk("idleStallMdD", {31'd0, m.stall_req}, 32'd0);
      m.md_in_D = 1'b0;
      step();

      runOp(3'd1, 32'hFFFFFFFE, 32'd3, 1'b0, 0);
      chk("multHiVal", m.hi, 32'hFFFFFFFF);
      chk("multLoVal", m.lo, 32'hFFFFFFFA);
      runOp(3'd3, 32'hFFFFFFF9, 32'd2, 1'b0, 0);
      chk("divLoVal", m.lo, 32'hFFFFFFFD);
      chk("divHiVal", m.hi, 32'hFFFFFFFF);
      runOp(3'd4, 32'd7, 32'd2, 1'b0, 0);
      chk("divuLoVal", m.lo, 32'd3);
      chk("divuHiVal", m.hi, 32'd1);
      runOp(3'd3, 32'd1234, 32'd0, 1'b0, 0);
      chk("div0Hi", m.hi, 32'd1);
      chk("div0Lo", m.lo, 32'd3);
      runOp(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 0);
      runShort(3'd5, 32'h12345678);
      chk("mthiVal", m.hi, 32'h12345678);
      runShort(3'd7, 32'h55AA55AA);
      runOp(3'd4, 32'd100, 32'd7, 1'b0, 3);
      chk("ignoreLo", m.lo, 32'd14);
      runOp(3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b1, 0);
      chk("ovfLo", m.lo, 32'h80000000);
      chk("ovfHi", m.hi, 32'd0);

      for (int i = 0; i < 30; i++) begin
         ro = 3'($urandom_range(1, 7));
         ra = $urandom;
         rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
         if (ro >= 3'd5) runShort(ro, ra);
         else runOp(ro, ra, rb, 1'($urandom_range(0, 1)), 0);
      end

      m.start = 1'b1; m.op = 3'd1; m.rs_val = 32'h00010000; m.rt_val = 32'h00010000;
      step();
      m.start = 1'b0; m.op = 3'd0;
      step();
      reset = 1'b0;
      #1;
      chk("midRstBusy", {31'd0, m.busy}, 32'd0);
      chk("midRstHi", m.hi, 32'd0);
      chk("midRstLo", m.lo, 32'd0);
      step();
      reset = 1'b1;
      for (int k = 0; k < 10; k++) begin
         step();
         chk("noLateHi", m.hi, 32'd0);
         chk("noLateBusy", {31'd0, m.busy}, 32'd0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
